// File: rtl/rc_settle_monitor.sv
// Settling monitor for ADC samples of an RC output node: finds the first run of HOLD in-band samples,
// or reports a timeout. Optional feature macro RC_SETTLE_MON_AVG_EN compares a two-sample average.
module rc_settle_monitor #(
    parameter int DW   = 12,
    parameter int TW   = 16,
    parameter int TOL  = 4,
    parameter int HOLD = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] target,
    input  logic          s_valid,
    input  logic [DW-1:0] s_data,
    output logic          s_ready,
    output logic          busy,
    output logic          done,
    output logic          settled,
    output logic          timeout,
    output logic [TW-1:0] settle_idx
);

    typedef enum logic [1:0] {ST_IDLE, ST_TRACK, ST_DONE} state_t;

    // Handshake: a sample moves only on a cycle where s_valid && s_ready;
    // s_ready is high exactly while tracking, and start overrides any sample that cycle.
    state_t        state, state_nxt;
    logic [DW-1:0] target_q;
    logic [TW-1:0] idx, run, first;
    logic [DW-1:0] cmp;
    logic [DW:0]   diff, err;
    logic          accept, in_band, hit, exhausted;
    logic [TW-1:0] run_inc, first_eff;

`ifdef RC_SETTLE_MON_AVG_EN
    logic [DW-1:0] prev;
    logic [DW:0]   sum;

    // idx is 0 only on the first sample after start, where prev is not yet meaningful
    always_comb begin
        sum = {1'b0, s_data} + {1'b0, prev};
        cmp = (idx == '0) ? s_data : sum[DW:1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      prev <= '0;
        else if (accept) prev <= s_data;
    end
`else
    assign cmp = s_data;
`endif

    assign accept    = s_valid && (state == ST_TRACK) && !start;
    assign diff      = {1'b0, cmp} - {1'b0, target_q};
    assign err       = diff[DW] ? -diff : diff;
    assign in_band   = (err <= (DW+1)'(TOL));
    assign run_inc   = run + TW'(1);
    assign hit       = in_band && (run_inc == TW'(HOLD));
    assign exhausted = (idx == '1);
    assign first_eff = (run == '0) ? idx : first;

    assign s_ready = (state == ST_TRACK);
    assign busy    = (state == ST_TRACK);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = ST_TRACK;
        end else begin
            case (state)
                ST_TRACK: if (accept && (hit || exhausted)) state_nxt = ST_DONE;
                default:  state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target_q   <= '0;
            idx        <= '0;
            run        <= '0;
            first      <= '0;
            done       <= 1'b0;
            settled    <= 1'b0;
            timeout    <= 1'b0;
            settle_idx <= '0;
        end else if (start) begin
            target_q   <= target;
            idx        <= '0;
            run        <= '0;
            first      <= '0;
            done       <= 1'b0;
            settled    <= 1'b0;
            timeout    <= 1'b0;
            settle_idx <= '0;
        end else if (accept) begin
            run   <= in_band ? run_inc : '0;
            first <= in_band ? first_eff : first;
            idx   <= exhausted ? idx : idx + TW'(1);
            // a run completing on the last index wins over the timeout
            if (hit) begin
                done       <= 1'b1;
                settled    <= 1'b1;
                settle_idx <= first_eff;
            end else if (exhausted) begin
                done       <= 1'b1;
                timeout    <= 1'b1;
                settle_idx <= '1;
            end
        end
    end

endmodule
